// File: rtl/elevator_pkg.sv
// Shared types for the elevator control path: floor encoding and scheduler states.
package elevator_pkg;

  localparam int FLOOR_W    = 3;
  localparam int NUM_FLOORS = 8;

  typedef logic [FLOOR_W-1:0] floor_t;

  typedef enum logic [1:0] {
    IDLE,
    MOVE_UP,
    MOVE_DOWN,
    DOOR
  } sched_state_t;

endpackage

// File: rtl/elevator_request_scheduler_floor_pick.sv
// Combinational request classifier: splits the pending vector around the
// current floor and finds the nearest request on each side.
module floor_pick
  import elevator_pkg::*;
(
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    cur_floor,
  input  logic                  dir_up,
  output logic                  above,
  output logic                  below,
  output logic                  here,
  output logic                  go_up,
  output logic [FLOOR_W-1:0]    lo_above,
  output logic [FLOOR_W-1:0]    hi_below
);

  // Nearest request above (lowest index) and below (highest index) the car.
  always_comb begin
    above    = 1'b0;
    below    = 1'b0;
    lo_above = '0;
    hi_below = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending[i] && (i > int'(cur_floor))) begin
        above    = 1'b1;
        lo_above = floor_t'(i);
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i] && (i < int'(cur_floor))) begin
        below    = 1'b1;
        hi_below = floor_t'(i);
      end
    end
  end

  // SCAN preference: go up when work lies above and either the car prefers
  // up or there is nothing below to serve instead.
  always_comb begin
    here  = pending[cur_floor];
    go_up = above && (dir_up || !below);
  end

endmodule

// File: rtl/elevator_request_scheduler.sv
// SCAN request scheduler: latches floor calls, picks the next target floor
// for the elevator FSM and runs the door dwell on each served floor.
module elevator_request_scheduler
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS  = 8,
  parameter int DOOR_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic [FLOOR_W-1:0]    cur_floor,
  output logic [FLOOR_W-1:0]    target_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  dir_up,
  output logic                  door_open,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DOOR_CYCLES + 1);

  sched_state_t          state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [NUM_FLOORS-1:0] pending_nxt;
  logic [NUM_FLOORS-1:0] cur_mask;
  logic [FLOOR_W-1:0]    target_nxt;
  logic                  dir_nxt;
  logic                  absorb;
  logic                  dwell_end;
  logic                  above, below, here, go_up;
  logic [FLOOR_W-1:0]    lo_above, hi_below;

  floor_pick u_pick (
    .pending   (pending),
    .cur_floor (cur_floor),
    .dir_up    (dir_up),
    .above     (above),
    .below     (below),
    .here      (here),
    .go_up     (go_up),
    .lo_above  (lo_above),
    .hi_below  (hi_below)
  );

  // Request latch: a call for the open-door floor is absorbed instead of
  // latched, and the served floor is dropped when its dwell finishes.
  always_comb begin
    cur_mask    = NUM_FLOORS'(1) << cur_floor;
    absorb      = (state == DOOR) && call_req[cur_floor];
    dwell_end   = (state == DOOR) && (cnt <= CNT_W'(1));
    pending_nxt = pending | call_req;
    if (state == DOOR) begin
      pending_nxt = pending | (call_req & ~cur_mask);
    end
    if (dwell_end) begin
      pending_nxt = pending_nxt & ~cur_mask;
    end
  end

  // SCAN next-state, dwell counter, direction and target selection.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (here)       state_nxt = DOOR;
        else if (go_up) state_nxt = MOVE_UP;
        else if (below) state_nxt = MOVE_DOWN;
        else            state_nxt = IDLE;
      end
      MOVE_UP: begin
        if (here)       state_nxt = DOOR;
        else if (above) state_nxt = MOVE_UP;
        else if (below) state_nxt = MOVE_DOWN;
        else            state_nxt = IDLE;
      end
      MOVE_DOWN: begin
        if (here)       state_nxt = DOOR;
        else if (below) state_nxt = MOVE_DOWN;
        else if (above) state_nxt = MOVE_UP;
        else            state_nxt = IDLE;
      end
      DOOR: begin
        // A repeated call at this floor keeps the doors open for a full dwell.
        if (absorb) begin
          state_nxt = DOOR;
          cnt_nxt   = CNT_W'(DOOR_CYCLES);
        end else if (dwell_end) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    if ((state != DOOR) && (state_nxt == DOOR)) begin
      cnt_nxt = CNT_W'(DOOR_CYCLES);
    end

    dir_nxt    = dir_up;
    target_nxt = cur_floor;
    case (state_nxt)
      MOVE_UP: begin
        dir_nxt    = 1'b1;
        target_nxt = lo_above;
      end
      MOVE_DOWN: begin
        dir_nxt    = 1'b0;
        target_nxt = hi_below;
      end
      default: begin
        dir_nxt    = dir_up;
        target_nxt = cur_floor;
      end
    endcase
  end

  // State and registered outputs; reset drops all outstanding requests.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      pending      <= '0;
      target_floor <= '0;
      dir_up       <= 1'b1;
      door_open    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      pending      <= pending_nxt;
      target_floor <= target_nxt;
      dir_up       <= dir_nxt;
      door_open    <= (state_nxt == DOOR);
      busy         <= (state_nxt != IDLE);
    end
  end

endmodule

// File: doc/elevator_request_scheduler.md
Name: elevator_request_scheduler

Overview:
- Upstream stage of the elevator floor FSM.
- Latches floor-call buttons and chooses the next target floor using SCAN: continue in the current direction while requests remain that way, then reverse.
- Drives the FSM's 3-bit target-floor input and takes the FSM's current-floor output back as feedback.
- Runs a door-dwell timer on each served floor and clears the served request when the dwell ends.

Parameters:
- NUM_FLOORS, 8: number of floors. Fixed at 8 in this revision, matching the 3-bit floor encoding.
- DOOR_CYCLES, 4: door-open dwell length in clk cycles. Must be at least 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- call_req  in  8  one-cycle-or-longer request pulses; bit i = call for floor i.
- cur_floor  in  3  current floor, fed back from the elevator FSM output.
- target_floor  out  3  registered target floor; drives the FSM floor input.
- pending  out  8  registered outstanding-request vector.
- dir_up  out  1  registered direction; 1 = up, 0 = down.
- door_open  out  1  registered; high during dwell.
- busy  out  1  registered; high in any state other than IDLE.

Behaviour:
- Reset (rst low, asynchronous) sets the following:
  - state = IDLE, pending = 0, target_floor = 0, dir_up = 1, door_open = 0, busy = 0, dwell counter = 0.
- Request latch, every cycle:
  - pending |= call_req, except a bit equal to cur_floor while the state is DOOR. That request is absorbed and restarts dwell at DOOR_CYCLES.
  - Bits already set remain set until their floor is served.
- Definitions:
  - above = pending bits with index > cur_floor.
  - below = pending bits with index < cur_floor.
  - here = pending[cur_floor].
- State machine (states live in the shared enum):
  - IDLE:
    - If here → DOOR.
    - Else if above and below are both non-empty → move in the dir_up direction.
    - Else if above is non-empty → MOVE_UP.
    - Else if below is non-empty → MOVE_DOWN.
    - Else stay in IDLE.
  - MOVE_UP:
    - If here → DOOR.
    - Else if above is non-empty → stay.
    - Else if below is non-empty → MOVE_DOWN.
    - Else → IDLE.
  - MOVE_DOWN: mirror image of MOVE_UP.
  - DOOR:
    - Counter loads DOOR_CYCLES on entry and decrements each cycle.
    - When the counter reaches 1, clear pending[cur_floor] and go to IDLE.
    - IDLE then re-evaluates on the next cycle and keeps the dir_up preference.
- dir_up is written on entry to MOVE_UP (1) and MOVE_DOWN (0), and held otherwise.
- target_floor is registered from the next-state decision:
  - MOVE_UP: lowest set index in above.
  - MOVE_DOWN: highest set index in below.
  - IDLE and DOOR: cur_floor.
  - Latency is 1 clk from a cur_floor or pending change to the target update.
- Intermediate calls: a call that lands between cur_floor and the current target replaces the target on the next cycle, so the car stops there first.
- Outputs:
  - door_open = 1 exactly DOOR_CYCLES cycles per service.
  - busy = (state != IDLE).
- Boundaries:
  - At floor 7, above is always empty; at floor 0, below is always empty.
  - In MOVE states, cur_floor stepping past the target cannot occur. If it does, the above/below recomputation self-corrects without special casing.
  - A call for cur_floor in IDLE is served in place: go to DOOR, no motion.
  - Simultaneous calls: all are latched in the same cycle.
  - Reset mid-dwell or mid-move drops all pending requests.
- The elevator FSM's idle_flag is not consumed. The scheduler must hold target_floor = cur_floor when there is no work, so that the FSM's idle logic can engage.

Decomposition:
- Shared package elevator_pkg holds:
  - FLOOR_W = 3 and NUM_FLOORS = 8.
  - floor_t typedef (logic [2:0]).
  - sched_state_t enum {IDLE, MOVE_UP, MOVE_DOWN, DOOR}.
- One natural sub-module: floor_pick. It is combinational: from pending, cur_floor and dir it returns the above/below/here flags, the lowest-above index and the highest-below index. The top module instantiates it once.

Test Plan:
- Reset, cur_floor=0, call_req=8'h20 → next cycle pending=8'h20. Following cycle MOVE_UP, target_floor=5, dir_up=1. Drive cur_floor 0→5 → door_open high 4 cycles, then pending=0, busy=0, target_floor=5.
- cur_floor=3, call_req=8'h08 in IDLE → DOOR with no motion, target_floor=3, door_open 4 cycles, pending[3] cleared.
- cur_floor=2, moving up to 6 (pending=8'h40), then call floor 4 → target_floor changes 6→4 one cycle later. Stop at 4 (door), then resume with target_floor=6.
- At floor 4 going up, pending=8'h82 (floors 7 and 1) → serve 7 first. Then dir_up=0, target_floor=1.
- In DOOR at floor 2 with counter=1, call_req bit 2 asserted → dwell restarts; door_open stays high 4 more cycles, pending[2] stays 0.
- Reset asserted mid-move with pending=8'hFF → immediately pending=0, state IDLE, door_open=0, target_floor=0, dir_up=1.
